// File: rtl/gap_junction_sequencer.sv
// Run controller for the GapJunction HLS core: launches num_runs ap_ctrl_hs invocations per command,
// streams input_r, drains and checks output_r framing, and watchdogs each run.
module gap_junction_sequencer #(
  parameter int IN_BEATS           = 216,
  parameter int OUT_BEATS          = 24,
  parameter int Stop_Counter_Value = 20000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  num_runs,
  output logic        ap_start_0,
  input  logic        ap_done_0,
  output logic        input_r_TVALID_0,
  input  logic        input_r_TREADY_0,
  output logic [31:0] input_r_TDATA_0,
  output logic        input_r_TLAST_0,
  input  logic        output_r_TVALID_0,
  output logic        output_r_TREADY_0,
  input  logic [31:0] output_r_TDATA_0,
  input  logic        output_r_TLAST_0,
  output logic        busy,
  output logic        done,
  output logic [7:0]  runs_done,
  output logic [3:0]  Error_Counter,
  output logic        timeout_flag,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_STREAM = 3'd2,
    S_NEXT   = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  localparam logic [23:0] IN_N     = 24'(IN_BEATS);
  localparam logic [23:0] IN_LAST  = 24'(IN_BEATS - 1);
  localparam logic [15:0] OUT_N    = 16'(OUT_BEATS);
  localparam logic [15:0] OUT_LAST = 16'(OUT_BEATS - 1);
  localparam logic [19:0] WD_LAST  = 20'(Stop_Counter_Value - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_num_runs;
  logic [7:0]  r_runs_done;
  logic [23:0] r_in_cnt;
  logic [15:0] r_out_cnt;
  logic        r_done_seen;
  logic [19:0] r_wd;
  logic        r_ap_start;
  logic [3:0]  r_err;
  logic        r_timeout;

  logic        w_in_valid;
  logic        w_out_ready;
  logic        w_in_hs;
  logic        w_out_hs;
  logic        w_stream_done;
  logic        w_wd_event;
  logic        w_wd_expire;
  logic        w_err_early;
  logic        w_err_miss;
  logic        w_err_surplus;
  logic [1:0]  w_err_inc;
  logic [4:0]  w_err_sum;
  logic [3:0]  w_err_nxt;
  logic        w_unused_tdata;

  // Both streams use AXI-Stream rules: a beat transfers on a rising edge where VALID and READY are
  // both high; VALID and its payload never drop or change while waiting for READY.
  assign w_in_valid    = (r_state == S_STREAM) && (r_in_cnt < IN_N);
  assign w_out_ready   = (r_state == S_STREAM);
  assign w_in_hs       = w_in_valid && input_r_TREADY_0;
  assign w_out_hs      = w_out_ready && output_r_TVALID_0;
  assign w_stream_done = (r_in_cnt == IN_N) && (r_out_cnt >= OUT_N) && r_done_seen;
  assign w_wd_event    = w_in_hs || w_out_hs || ap_done_0;
  assign w_wd_expire   = (r_state == S_STREAM) && !w_stream_done && !w_wd_event && (r_wd == WD_LAST);

  assign w_err_early   = w_out_hs && output_r_TLAST_0 && (r_out_cnt != OUT_LAST);
  assign w_err_miss    = w_out_hs && !output_r_TLAST_0 && (r_out_cnt == OUT_LAST);
  assign w_err_surplus = w_out_hs && (r_out_cnt >= OUT_N);
  assign w_err_inc     = {1'b0, w_err_early} + {1'b0, w_err_miss} + {1'b0, w_err_surplus}
                       + {1'b0, w_wd_expire};
  assign w_err_sum     = {1'b0, r_err} + {3'b000, w_err_inc};
  assign w_err_nxt     = (w_err_sum > 5'd15) ? 4'hF : w_err_sum[3:0];

  assign w_unused_tdata = ^output_r_TDATA_0;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = (num_runs == 8'd0) ? S_FINISH : S_LAUNCH;
      S_LAUNCH: w_state_nxt = S_STREAM;
      S_STREAM: begin
        if (w_stream_done)    w_state_nxt = S_NEXT;
        else if (w_wd_expire) w_state_nxt = S_FINISH;
      end
      S_NEXT:   w_state_nxt = ((r_runs_done + 8'd1) == r_num_runs) ? S_FINISH : S_LAUNCH;
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_num_runs  <= 8'd0;
      r_runs_done <= 8'd0;
      r_in_cnt    <= 24'd0;
      r_out_cnt   <= 16'd0;
      r_done_seen <= 1'b0;
      r_wd        <= 20'd0;
      r_ap_start  <= 1'b0;
      r_err       <= 4'd0;
      r_timeout   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ap_start <= 1'b0;
          if (start) begin
            r_num_runs  <= num_runs;
            r_runs_done <= 8'd0;
            r_err       <= 4'd0;
            r_timeout   <= 1'b0;
          end
        end
        S_LAUNCH: begin
          r_ap_start  <= 1'b1;
          r_in_cnt    <= 24'd0;
          r_out_cnt   <= 16'd0;
          r_done_seen <= 1'b0;
          r_wd        <= 20'd0;
        end
        S_STREAM: begin
          r_err <= w_err_nxt;
          if (w_in_hs) r_in_cnt <= r_in_cnt + 24'd1;
          // Saturate so a babbling core cannot wrap the count back into the legal range.
          if (w_out_hs && (r_out_cnt != 16'hFFFF)) r_out_cnt <= r_out_cnt + 16'd1;
          if (ap_done_0) begin
            r_done_seen <= 1'b1;
            r_ap_start  <= 1'b0;
          end
          if (w_wd_event) r_wd <= 20'd0;
          else            r_wd <= r_wd + 20'd1;
          if (w_wd_expire) begin
            r_timeout  <= 1'b1;
            r_ap_start <= 1'b0;
          end
        end
        S_NEXT:   r_runs_done <= r_runs_done + 8'd1;
        default: ;
      endcase
    end
  end

  assign ap_start_0        = r_ap_start;
  assign input_r_TVALID_0  = w_in_valid;
  assign input_r_TDATA_0   = w_in_valid ? {r_runs_done, r_in_cnt} : 32'd0;
  assign input_r_TLAST_0   = w_in_valid && (r_in_cnt == IN_LAST);
  assign output_r_TREADY_0 = w_out_ready;
  assign busy              = (r_state != S_IDLE);
  assign done              = (r_state == S_FINISH);
  assign runs_done         = r_runs_done;
  assign Error_Counter     = r_err;
  assign timeout_flag      = r_timeout;
  assign dbg_state         = r_state;

endmodule

// File: tb/tb_gap_junction_sequencer.sv
// Directed bench for gap_junction_sequencer: a behavioural core model feeds the streams while one
// linear initial block issues commands and checks results with immediate assertions.
module tb_gap_junction_sequencer;

  localparam int IN_BEATS = 216;
  localparam int WD_LIMIT = 20000;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  num_runs;
  logic        ap_start_0;
  logic        ap_done_0;
  logic        input_r_TVALID_0;
  logic        input_r_TREADY_0;
  logic [31:0] input_r_TDATA_0;
  logic        input_r_TLAST_0;
  logic        output_r_TVALID_0;
  logic        output_r_TREADY_0;
  logic [31:0] output_r_TDATA_0;
  logic        output_r_TLAST_0;
  logic        busy;
  logic        done;
  logic [7:0]  runs_done;
  logic [3:0]  Error_Counter;
  logic        timeout_flag;
  logic [2:0]  dbg_state;

  gap_junction_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .num_runs(num_runs),
    .ap_start_0(ap_start_0), .ap_done_0(ap_done_0),
    .input_r_TVALID_0(input_r_TVALID_0), .input_r_TREADY_0(input_r_TREADY_0),
    .input_r_TDATA_0(input_r_TDATA_0), .input_r_TLAST_0(input_r_TLAST_0),
    .output_r_TVALID_0(output_r_TVALID_0), .output_r_TREADY_0(output_r_TREADY_0),
    .output_r_TDATA_0(output_r_TDATA_0), .output_r_TLAST_0(output_r_TLAST_0),
    .busy(busy), .done(done), .runs_done(runs_done), .Error_Counter(Error_Counter),
    .timeout_flag(timeout_flag), .dbg_state(dbg_state)
  );

  int checks = 0;
  int failures = 0;

  // Core model configuration (written by the main sequence only).
  bit in_toggle = 0;
  int n_out = 24;
  int last_idx = 23;
  int early_idx = -1;
  bit send_done = 1;
  int rise_base = 0;

  // Core model observations (written by the core model only).
  int rise_total = 0;
  int in_total = 0;
  int in_tlast_total = 0;
  int stall_total = 0;
  int stream_err = 0;
  int last_hs_edge = 0;
  int cyc = 0;

  // ---------------- clock / edge counter ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- core model (drives at negedge, predicts next-edge handshakes) ----------------
  initial begin
    int in_seen;
    int out_sent;
    bit core_active;
    bit prev_ap_start;
    bit prev_stall;
    bit tog;
    logic [31:0] held_data;
    logic        held_last;
    logic [31:0] exp_data;
    in_seen = 0; out_sent = 0; core_active = 0; prev_ap_start = 0; prev_stall = 0; tog = 0;
    held_data = 32'd0; held_last = 1'b0;
    ap_done_0 = 1'b0;
    input_r_TREADY_0 = 1'b0;
    output_r_TVALID_0 = 1'b0;
    output_r_TDATA_0 = 32'd0;
    output_r_TLAST_0 = 1'b0;
    forever begin
      @(negedge clk);
      ap_done_0 = 1'b0;
      if (reset) begin
        prev_stall = 0;
        prev_ap_start = 0;
        output_r_TVALID_0 = 1'b0;
        output_r_TLAST_0 = 1'b0;
      end else begin
        if (ap_start_0 && !prev_ap_start) begin
          rise_total++;
          core_active = 1;
          in_seen = 0;
          out_sent = 0;
        end
        prev_ap_start = ap_start_0;

        tog = ~tog;
        input_r_TREADY_0 = in_toggle ? tog : 1'b1;
        if (prev_stall && !(input_r_TVALID_0 && input_r_TDATA_0 === held_data &&
                            input_r_TLAST_0 === held_last))
          stream_err++;
        if (input_r_TVALID_0) begin
          if (input_r_TREADY_0) begin
            exp_data = {8'(rise_total - rise_base - 1), 24'(in_seen)};
            if (in_seen >= IN_BEATS || input_r_TDATA_0 !== exp_data ||
                input_r_TLAST_0 !== (in_seen == IN_BEATS - 1))
              stream_err++;
            if (input_r_TLAST_0) in_tlast_total++;
            in_seen++;
            in_total++;
            last_hs_edge = cyc + 1;
            prev_stall = 0;
          end else begin
            prev_stall = 1;
            held_data = input_r_TDATA_0;
            held_last = input_r_TLAST_0;
            stall_total++;
          end
        end else begin
          prev_stall = 0;
        end

        if (core_active && in_seen >= IN_BEATS && out_sent < n_out) begin
          output_r_TVALID_0 = 1'b1;
          output_r_TDATA_0 = 32'(out_sent);
          output_r_TLAST_0 = (out_sent == last_idx) || (out_sent == early_idx);
          if (output_r_TREADY_0) begin
            out_sent++;
            last_hs_edge = cyc + 1;
            if (out_sent == n_out && send_done) begin
              ap_done_0 = 1'b1;
              core_active = 0;
            end
          end
        end else begin
          output_r_TVALID_0 = 1'b0;
          output_r_TLAST_0 = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_core(input bit tgl, input int nout, input int lidx, input int eidx,
                          input bit sdone);
    in_toggle = tgl;
    n_out = nout;
    last_idx = lidx;
    early_idx = eidx;
    send_done = sdone;
  endtask

  task automatic do_start(input logic [7:0] n);
    @(negedge clk);
    rise_base = rise_total;
    num_runs = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  int to_edge = -1;

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (timeout_flag && to_edge < 0) to_edge = cyc;
      if (done) begin
        ok = 1;
        break;
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit ok;
    int ib, tb0, sb, eb;
    reset = 1'b1;
    start = 1'b0;
    num_runs = 8'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ap_start", ap_start_0, 0);
    check("rst_in_valid", input_r_TVALID_0, 0);
    check("rst_out_ready", output_r_TREADY_0, 0);
    check("rst_runs_done", runs_done, 0);
    check("rst_errors", Error_Counter, 0);
    check("rst_timeout", timeout_flag, 0);

    // Single clean run.
    set_core(0, 24, 23, -1, 1);
    ib = in_total; tb0 = in_tlast_total; eb = stream_err;
    do_start(8'd1);
    wait_done(2000, ok);
    check("t1_done_seen", ok, 1);
    check("t1_runs_done", runs_done, 1);
    check("t1_errors", Error_Counter, 0);
    check("t1_in_beats", in_total - ib, IN_BEATS);
    check("t1_in_tlast", in_tlast_total - tb0, 1);
    check("t1_starts", rise_total - rise_base, 1);
    check("t1_stream", stream_err - eb, 0);
    @(negedge clk);
    check("t1_idle", busy, 0);

    // Three runs under input backpressure.
    set_core(1, 24, 23, -1, 1);
    ib = in_total; tb0 = in_tlast_total; sb = stall_total; eb = stream_err;
    do_start(8'd3);
    wait_done(5000, ok);
    check("t2_done_seen", ok, 1);
    check("t2_runs_done", runs_done, 3);
    check("t2_errors", Error_Counter, 0);
    check("t2_starts", rise_total - rise_base, 3);
    check("t2_in_beats", in_total - ib, 3 * IN_BEATS);
    check("t2_in_tlast", in_tlast_total - tb0, 3);
    check("t2_stalled", (stall_total - sb) > 0, 1);
    check("t2_stream", stream_err - eb, 0);

    // Early TLAST, missing TLAST and a surplus beat.
    set_core(0, 25, -1, 10, 1);
    do_start(8'd1);
    wait_done(2000, ok);
    check("t3_done_seen", ok, 1);
    check("t3_errors", Error_Counter, 3);
    check("t3_runs_done", runs_done, 1);

    // Core never signals ap_done: watchdog aborts the whole command.
    set_core(0, 24, 23, -1, 0);
    to_edge = -1;
    do_start(8'd2);
    wait_done(WD_LIMIT + 5000, ok);
    check("t4_done_seen", ok, 1);
    check("t4_timeout", timeout_flag, 1);
    check("t4_wd_cycles", to_edge - last_hs_edge, WD_LIMIT);
    check("t4_errors", Error_Counter, 1);
    check("t4_ap_start", ap_start_0, 0);
    check("t4_runs_done", runs_done, 0);
    check("t4_starts", rise_total - rise_base, 1);

    // Twenty surplus beats saturate the error counter.
    set_core(0, 44, 23, -1, 1);
    do_start(8'd1);
    wait_done(2000, ok);
    check("t5_done_seen", ok, 1);
    check("t5_errors_sat", Error_Counter, 15);
    check("t5_timeout_clr", timeout_flag, 0);

    // Zero-run command completes without launching the core.
    do_start(8'd0);
    check("t5z_done", done, 1);
    check("t5z_errors_clr", Error_Counter, 0);
    check("t5z_ap_start", ap_start_0, 0);
    @(negedge clk);
    check("t5z_done_pulse", done, 0);
    check("t5z_idle", busy, 0);
    check("t5z_starts", rise_total - rise_base, 0);

    // Reset in the middle of streaming, then a clean run.
    set_core(0, 24, 23, -1, 1);
    ib = in_total;
    do_start(8'd2);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (in_total - ib >= 50) begin
        ok = 1;
        break;
      end
    end
    check("t6_reached_stream", ok, 1);
    reset = 1'b1;
    @(negedge clk);
    check("t6_busy", busy, 0);
    check("t6_ap_start", ap_start_0, 0);
    check("t6_in_valid", input_r_TVALID_0, 0);
    check("t6_in_data", input_r_TDATA_0, 0);
    check("t6_out_ready", output_r_TREADY_0, 0);
    check("t6_state", dbg_state, 0);
    reset = 1'b0;
    eb = stream_err;
    do_start(8'd1);
    wait_done(2000, ok);
    check("t6_done_seen", ok, 1);
    check("t6_runs_done", runs_done, 1);
    check("t6_errors", Error_Counter, 0);
    check("t6_stream", stream_err - eb, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
